// File: rtl/spi_bridge_pkg.sv
// Shared encodings for the SPI register bridge: FSM states and header R/W bit values.
package spi_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic SPI_WR = 1'b1;
   localparam logic SPI_RD = 1'b0;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Register-bus side of the SPI bridge; the bridge drives it through the master modport.
interface spi_reg_bridge_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) ();

   logic [ADDR_W-1:0] addr_bus;
   logic [DATA_W-1:0] data_write_bus;
   logic              wr_enable_bus;
   logic              rd_enable_bus;
   logic [DATA_W-1:0] data_read_bus;

   modport master (
      output addr_bus, data_write_bus, wr_enable_bus, rd_enable_bus,
      input  data_read_bus
   );

   modport slave (
      input  addr_bus, data_write_bus, wr_enable_bus, rd_enable_bus,
      output data_read_bus
   );

endinterface

// File: rtl/spi_edge_sync.sv
// Oversampling synchroniser for the SPI pins plus sample/shift and select edge detection.
module spi_edge_sync #(
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic mosi,
   input  logic ssel,
   output logic sample_pulse,
   output logic shift_pulse,
   output logic ssel_fall,
   output logic ssel_rise,
   output logic sync_mosi,
   output logic sync_ssel
);

   localparam logic IDLE_LVL = (CPOL != 0) ? 1'b1 : 1'b0;

   logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, ssel_sr;
   logic                   sclk_d, ssel_d, sclk_s;
   logic                   lead, trail;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sr <= {SYNC_STAGES{IDLE_LVL}};
         mosi_sr <= '0;
         ssel_sr <= '1;
         sclk_d  <= IDLE_LVL;
         ssel_d  <= 1'b1;
      end else begin
         sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
         mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
         ssel_sr <= {ssel_sr[SYNC_STAGES-2:0], ssel};
         sclk_d  <= sclk_s;
         ssel_d  <= sync_ssel;
      end
   end

   assign sclk_s    = sclk_sr[SYNC_STAGES-1];
   assign sync_mosi = mosi_sr[SYNC_STAGES-1];
   assign sync_ssel = ssel_sr[SYNC_STAGES-1];

   // Leading edge leaves the idle level, trailing edge returns to it.
   assign lead  = (sclk_s != sclk_d) && (sclk_s != IDLE_LVL);
   assign trail = (sclk_s != sclk_d) && (sclk_s == IDLE_LVL);

   assign sample_pulse = (CPHA != 0) ? trail : lead;
   assign shift_pulse  = (CPHA != 0) ? lead  : trail;
   assign ssel_fall    = ssel_d & ~sync_ssel;
   assign ssel_rise    = ~ssel_d & sync_ssel;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI slave to register-bus bridge with burst frames and address auto-increment.
// Defining SPI_REG_BRIDGE_ERR_EN adds truncated-frame reporting (o_frame_err, o_err_count).
module spi_reg_bridge
   import spi_bridge_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_SCLK,
   input  logic       i_MOSI,
   input  logic       i_SSEL,
   output logic       o_MISO,
   output logic       o_MISO_oe,
`ifdef SPI_REG_BRIDGE_ERR_EN
   output logic       o_frame_err,
   output logic [7:0] o_err_count,
`endif
   spi_reg_bridge_if.master bus
);

   localparam int HDR_W = ADDR_W + 1;
   localparam int SR_W  = (HDR_W > DATA_W) ? HDR_W : DATA_W;
   localparam int CNT_W = $clog2(SR_W + 1);

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic [SR_W-2:0]   rx_sr;
   logic [SR_W-1:0]   sr_next;
   logic [DATA_W-1:0] tx_sr;
   logic [ADDR_W-1:0] addr;
   logic              is_wr, rd_load;
   logic              hdr_done, word_done;
   logic              sample_pulse, shift_pulse, ssel_fall, ssel_rise, sync_mosi, sync_ssel;

   spi_edge_sync #(
      .CPOL        (CPOL),
      .CPHA        (CPHA),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk          (i_clk),
      .rst_n        (i_rst),
      .sclk         (i_SCLK),
      .mosi         (i_MOSI),
      .ssel         (i_SSEL),
      .sample_pulse (sample_pulse),
      .shift_pulse  (shift_pulse),
      .ssel_fall    (ssel_fall),
      .ssel_rise    (ssel_rise),
      .sync_mosi    (sync_mosi),
      .sync_ssel    (sync_ssel)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state <= IDLE;
      else        state <= state_next;
   end

   // A sample landing in the same cycle as SSEL rising still completes its word.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      sr_next    = {rx_sr, sync_mosi};
      hdr_done   = 1'b0;
      word_done  = 1'b0;
      if (state != IDLE && sample_pulse) begin
         cnt_next = cnt + 1'b1;
         if (state == HDR && cnt == CNT_W'(HDR_W - 1)) begin
            hdr_done   = 1'b1;
            cnt_next   = '0;
            state_next = DATA;
         end else if (state == DATA && cnt == CNT_W'(DATA_W - 1)) begin
            word_done = 1'b1;
            cnt_next  = '0;
         end
      end
      if (state == IDLE) begin
         if (ssel_fall) begin
            state_next = HDR;
            cnt_next   = '0;
         end
      end else if (ssel_rise) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt                <= '0;
         rx_sr              <= '0;
         tx_sr              <= '0;
         addr               <= '0;
         is_wr              <= 1'b0;
         rd_load            <= 1'b0;
         bus.addr_bus       <= '0;
         bus.data_write_bus <= '0;
         bus.wr_enable_bus  <= 1'b0;
         bus.rd_enable_bus  <= 1'b0;
      end else begin
         cnt               <= cnt_next;
         bus.wr_enable_bus <= 1'b0;
         bus.rd_enable_bus <= 1'b0;
         rd_load           <= bus.rd_enable_bus;
         if (state != IDLE && sample_pulse) rx_sr <= sr_next[SR_W-2:0];
         if (hdr_done) begin
            is_wr <= (sr_next[ADDR_W] == SPI_WR);
            addr  <= sr_next[ADDR_W-1:0];
            if (sr_next[ADDR_W] == SPI_RD) begin
               bus.addr_bus      <= sr_next[ADDR_W-1:0];
               bus.rd_enable_bus <= 1'b1;
            end
         end
         if (word_done) begin
            addr <= addr + 1'b1;
            if (is_wr) begin
               bus.addr_bus       <= addr;
               bus.data_write_bus <= sr_next[DATA_W-1:0];
               bus.wr_enable_bus  <= 1'b1;
            end else begin
               bus.addr_bus      <= addr + 1'b1;
               bus.rd_enable_bus <= 1'b1;
            end
         end
         // The first shift edge of each word keeps the freshly loaded MSB on the pin.
         if (state == IDLE && ssel_fall)
            tx_sr <= '0;
         else if (rd_load)
            tx_sr <= bus.data_read_bus;
         else if (state == DATA && shift_pulse && cnt != '0)
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
      end
   end

   assign o_MISO    = (state == DATA) && !is_wr && !sync_ssel && tx_sr[DATA_W-1];
   assign o_MISO_oe = !sync_ssel;

`ifdef SPI_REG_BRIDGE_ERR_EN
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_frame_err <= 1'b0;
         o_err_count <= '0;
      end else begin
         o_frame_err <= 1'b0;
         if (state != IDLE && ssel_rise && cnt_next != '0) begin
            o_frame_err <= 1'b1;
            if (o_err_count != 8'hFF) o_err_count <= o_err_count + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: one instance per SPI mode, random and directed frames.
// Build with SPI_REG_BRIDGE_ERR_EN defined to also cover the truncated-frame counter.
module tb_spi_reg_bridge;

   localparam int H = 8;

   typedef struct {
      int         inst;
      bit         wr;
      logic [6:0] addr;
      logic [7:0] data;
   } txn_t;

   typedef struct {
      int         inst;
      logic [7:0] data;
   } word_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       sclk [4];
   logic       mosi [4];
   logic       ssel [4];
   logic       miso [4];
   logic       miso_oe [4];
   logic       wr_en [4];
   logic       rd_en [4];
   logic [6:0] addr [4];
   logic [7:0] wdata [4];
   logic [7:0] rd_data [4];
`ifdef SPI_REG_BRIDGE_ERR_EN
   logic       frame_err [4];
   logic [7:0] err_count [4];
   int         err_pulses [4];
`endif

   for (genvar g = 0; g < 4; g++) begin : gen_dut
      spi_reg_bridge_if #(.ADDR_W(7), .DATA_W(8)) bus_if ();
      spi_reg_bridge #(
         .ADDR_W(7), .DATA_W(8), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)
      ) dut (
         .i_clk       (clk),
         .i_rst       (rst_n),
         .i_SCLK      (sclk[g]),
         .i_MOSI      (mosi[g]),
         .i_SSEL      (ssel[g]),
         .o_MISO      (miso[g]),
         .o_MISO_oe   (miso_oe[g]),
`ifdef SPI_REG_BRIDGE_ERR_EN
         .o_frame_err (frame_err[g]),
         .o_err_count (err_count[g]),
`endif
         .bus         (bus_if)
      );
      assign wr_en[g]                = bus_if.wr_enable_bus;
      assign rd_en[g]                = bus_if.rd_enable_bus;
      assign addr[g]                 = bus_if.addr_bus;
      assign wdata[g]                = bus_if.data_write_bus;
      assign bus_if.data_read_bus    = rd_data[g];
   end

   txn_t       exp_q[$];
   word_t      exp_miso[$];
   word_t      got_miso[$];
   string      chk_name[$];
   int         chk_act[$];
   int         chk_exp[$];
   logic [7:0] fb[$];
   logic [7:0] model_mem [128];
   int         err_exp [4];
   int         total = 0;
   int         bad = 0;

   function automatic logic [7:0] init_val(input int i);
      if (i == 10) return 8'h15;
      if (i == 11) return 8'h16;
      return 8'(i * 37 + 90);
   endfunction

   // Register file seen by the bridges: read data valid the cycle after the strobe.
   logic [7:0] regf [128];
   bit         mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 128; i++) regf[i] <= init_val(i);
         mem_ready <= 1'b1;
      end
      for (int g = 0; g < 4; g++) begin
         if (rd_en[g]) rd_data[g] <= regf[addr[g]];
         if (wr_en[g]) regf[addr[g]] <= wdata[g];
      end
   end

   // Monitor: all comparisons happen here, away from the active edge.
   txn_t  e;
   word_t gm, em;
   string cn;
   int    ca, ce;
   always @(negedge clk) begin
      for (int g = 0; g < 4; g++) begin
`ifdef SPI_REG_BRIDGE_ERR_EN
         if (frame_err[g] === 1'b1) err_pulses[g]++;
`endif
         if (wr_en[g] || rd_en[g]) begin
            total++;
            if (wr_en[g] && rd_en[g]) begin
               bad++;
               $display("FAIL strobe_overlap inst=%0d got both strobes, required one", g);
            end
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_strobe inst=%0d got wr=%0d addr=%h, required none", g, wr_en[g], addr[g]);
            end else begin
               e = exp_q.pop_front();
               if (e.inst != g || e.wr != wr_en[g] || e.addr != addr[g] || (e.wr && e.data != wdata[g])) begin
                  bad++;
                  $display("FAIL bus_txn got inst=%0d wr=%0d addr=%h data=%h required inst=%0d wr=%0d addr=%h data=%h",
                           g, wr_en[g], addr[g], wdata[g], e.inst, e.wr, e.addr, e.data);
               end
            end
         end
      end
      while (got_miso.size() > 0) begin
         gm = got_miso.pop_front();
         total++;
         if (exp_miso.size() == 0) begin
            bad++;
            $display("FAIL miso_extra inst=%0d got=%h required none", gm.inst, gm.data);
         end else begin
            em = exp_miso.pop_front();
            if (em.inst != gm.inst || em.data !== gm.data) begin
               bad++;
               $display("FAIL miso_word got inst=%0d data=%h required inst=%0d data=%h", gm.inst, gm.data, em.inst, em.data);
            end
         end
      end
      while (chk_name.size() > 0) begin
         cn = chk_name.pop_front();
         ca = chk_act.pop_front();
         ce = chk_exp.pop_front();
         total++;
         if (ca != ce) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", cn, ca, ce);
         end
      end
   end

   task automatic push_chk(input string n, input int act, input int req);
      chk_name.push_back(n);
      chk_act.push_back(act);
      chk_exp.push_back(req);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string n, input int g);
      logic [19:0] v;
      v = {addr[g], wdata[g], wr_en[g], rd_en[g], miso[g], miso_oe[g]};
      push_chk(n, (^v === 1'bx) ? -1 : int'(v), 0);
   endtask

   // SPI master: bits of fb MSB first; MISO captured at the master's sample edge.
   task automatic spi_frame(input int m, input int nbits, input int rst_at);
      bit         cpol, cpha;
      logic [7:0] cap;
      logic       b;
      cpol = (m >= 2);
      cpha = (m % 2 == 1);
      cap  = 8'h00;
      sclk[m] = cpol;
      ssel[m] = 1'b0;
      wait_cyc(H);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst_n = 1'b0;
            wait_cyc(2);
            check_idle_outputs("midframe_reset_outputs", m);
            ssel[m] = 1'b1;
            sclk[m] = cpol;
            wait_cyc(4);
            rst_n = 1'b1;
            wait_cyc(4);
            return;
         end
         b = fb[i / 8][7 - (i % 8)];
         if (!cpha) begin
            mosi[m] = b;
            wait_cyc(H);
         end else begin
            sclk[m] = !cpol;
            mosi[m] = b;
            wait_cyc(H);
         end
         if (i >= 8) begin
            cap = {cap[6:0], miso[m]};
            if (i % 8 == 7) got_miso.push_back('{m, cap});
            if (i == 8) push_chk("miso_oe_active", int'(miso_oe[m]), 1);
         end
         if (!cpha) begin
            sclk[m] = !cpol;
            wait_cyc(H);
            sclk[m] = cpol;
         end else begin
            sclk[m] = cpol;
            wait_cyc(H);
         end
      end
      wait_cyc(H);
      ssel[m] = 1'b1;
      wait_cyc(2 * H);
      push_chk("txn_drain", exp_q.size(), 0);
      push_chk("miso_drain", exp_miso.size(), 0);
      push_chk("miso_oe_idle", int'(miso_oe[m]), 0);
   endtask

   // Reference model: expected bus activity and MISO words from the frame bytes alone.
   task automatic issue_frame(input int m, input int nbits, input int rst_at);
      int         eff, nw;
      logic [7:0] h;
      logic [6:0] a, ai;
      eff = (rst_at >= 0 && rst_at < nbits) ? rst_at : nbits;
      if (eff >= 8) begin
         h  = fb[0];
         a  = h[6:0];
         nw = (eff - 8) / 8;
         if (h[7]) begin
            for (int i = 0; i < nw; i++) begin
               ai = a + 7'(i);
               exp_q.push_back('{m, 1'b1, ai, fb[i + 1]});
               model_mem[ai] = fb[i + 1];
               exp_miso.push_back('{m, 8'h00});
            end
         end else begin
            exp_q.push_back('{m, 1'b0, a, 8'h00});
            for (int i = 0; i < nw; i++) begin
               ai = a + 7'(i);
               exp_q.push_back('{m, 1'b0, ai + 7'd1, 8'h00});
               exp_miso.push_back('{m, model_mem[ai]});
            end
         end
      end
      if (rst_at < 0 && nbits > 0 && (nbits < 8 || (nbits - 8) % 8 != 0)) err_exp[m]++;
      spi_frame(m, nbits, rst_at);
      if (rst_at >= 0 && rst_at < nbits)
         for (int g = 0; g < 4; g++) err_exp[g] = 0;
   endtask

   initial begin
      int         nw, nbits, m;
      logic [7:0] h;
      for (int i = 0; i < 128; i++) model_mem[i] = init_val(i);
      for (int g = 0; g < 4; g++) begin
         sclk[g]    = (g >= 2);
         mosi[g]    = 1'b0;
         ssel[g]    = 1'b1;
         err_exp[g] = 0;
      end
      rst_n = 1'b0;
      wait_cyc(5);
      for (int g = 0; g < 4; g++) check_idle_outputs("reset_outputs", g);
      rst_n = 1'b1;
      wait_cyc(5);

      for (int md = 0; md < 4; md++) begin
         fb = {8'hC2, 8'h02};
         issue_frame(md, 16, -1);
         fb = {8'h0A, 8'h00, 8'h00};
         issue_frame(md, 24, -1);
      end

      fb = {8'hF3, 8'hFF, 8'hAA, 8'h55};
      issue_frame(0, 32, -1);
      fb = {8'hFF, 8'h11, 8'h22};
      issue_frame(0, 24, -1);
      fb = {8'h7F, 8'h00, 8'h00};
      issue_frame(1, 24, -1);

      fb = {8'hC2, 8'h02};
      issue_frame(0, 13, -1);
`ifdef SPI_REG_BRIDGE_ERR_EN
      push_chk("err_count", int'(err_count[0]), err_exp[0]);
      push_chk("err_pulses", err_pulses[0], err_exp[0]);
`endif

      fb = {8'hC2, 8'h5A};
      issue_frame(3, 16, 12);
      fb = {8'hC2, 8'h33};
      issue_frame(3, 16, -1);
      fb = {8'h42, 8'h00};
      issue_frame(3, 16, -1);

      for (int r = 0; r < 20; r++) begin
         m  = int'($urandom_range(0, 3));
         nw = int'($urandom_range(1, 3));
         h  = {1'($urandom_range(0, 1)), 7'($urandom)};
         fb.delete();
         fb.push_back(h);
         for (int i = 0; i < nw; i++) fb.push_back(8'($urandom));
         nbits = 8 + 8 * nw;
         if ($urandom_range(0, 4) == 0) nbits -= int'($urandom_range(1, 7));
         issue_frame(m, nbits, -1);
      end

      wait_cyc(20);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
